d_mem_responder: RTL
====================

// Module: d_mem_responder
// PURPOSE
//  Memory-side responder for RV32I core load/store requests: accepts requests over valid/ready,
//  performs the access on an internal synchronous-read word array, formats load data
//  (byte/half/word, sign/zero extend) and returns exactly one in-order response per request
//  over valid/ready. Serves as the data-memory endpoint for core tiles and core-level benches.
// PARAMETERS
//  XLEN            32    data/address width (RV32I); XLEN_BYTES = XLEN/8
//  MEM_DEPTH_WORDS 1024  array depth in XLEN words; must be a power of 2
//  TAG_W           4     request tag width, returned unchanged with the response
//  RSP_FIFO_DEPTH  4     in-flight/response buffer depth; power of 2, >= 3 for full throughput
// PORTS
//  Clk         in   1      clock, all state updates on rising edge
//  RstN        in   1      asynchronous, active-low reset
//  ReqValid    in   1      request valid
//  ReqReady    out  1      responder can accept a request this cycle
//  ReqAddr     in   XLEN   byte address
//  ReqWrEn     in   1      1 = store, 0 = load
//  ReqSize     in   2      00 byte, 01 half, 10 word, 11 illegal
//  ReqSignExt  in   1      loads only: 1 = sign-extend, 0 = zero-extend
//  ReqWrData   in   XLEN   store data, right-aligned (low byte/half/word)
//  ReqTag      in   TAG_W  request tag
//  RspValid    out  1      response valid
//  RspReady    in   1      consumer accepts response
//  RspData     out  XLEN   formatted load data; 0 for stores and errors
//  RspTag      out  TAG_W  tag of the request being answered
//  RspErr      out  1      request was misaligned, out of range or illegal size
// BEHAVIOUR
//  - Accept when ReqValid && ReqReady; at most one request per cycle; all request fields sampled then.
//  - ReqReady = (stage_valid + fifo_count) < RSP_FIFO_DEPTH; no combinational path RspReady->ReqReady.
//  - Error if ReqSize==11, half with ReqAddr[0]!=0, word with ReqAddr[1:0]!=0, or
//    ReqAddr[XLEN-1:2] >= MEM_DEPTH_WORDS. Error request: no array read/write, RspErr=1, RspData=0.
//  - Store: array write at acceptance edge with byte enables from ReqSize/ReqAddr[1:0];
//    byte data = ReqWrData[7:0] to lane addr[1:0], half = ReqWrData[15:0] to lane addr[1]. Store rsp: data 0, err 0.
//  - Load: word read at acceptance edge into stage register with addr[1:0], size, sign, tag;
//    formatted in stage, pushed into response FIFO at next edge.
//  - Latency: accept at edge N -> stage valid after N -> FIFO push at N+1 -> RspValid high
//    after edge N+1 (2 cycles) when FIFO was empty. Sustained 1 req/cycle with RspReady held high.
//  - Store then load to same address in consecutive cycles: load returns the stored data.
//  - Responses strictly in request order. RspValid = FIFO not empty; RspData/Tag/Err = FIFO head,
//    held stable while RspValid && !RspReady. Pop on RspValid && RspReady.
//  - FIFO push and pop in the same cycle: count unchanged; pointers wrap modulo RSP_FIFO_DEPTH.
//  - Credit rule guarantees no overflow; stage never stalls.
//  - Reset (async, any time): stage_valid=0, FIFO pointers/count=0, FIFO entries=0 ->
//    RspValid 0, RspData 0, RspTag 0, RspErr 0, ReqReady 1. In-flight requests dropped, no
//    response after reset. Array contents not reset; stores already performed persist.
// TESTING
//  1. SW 0x10 data 0xDEADBEEF tag 1, then LW 0x10 tag 2 -> rsp {tag1,0,err0}, {tag2,0xDEADBEEF,err0}; LW rsp 2 cycles after accept.
//  2. After 1: LB 0x13 signed -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
//  3. SB 0x11 data 0x123456AA, then LW 0x10 -> 0xDEADAAEF; SH 0x12 data 0x00001234 then LW 0x10 -> 0x1234AAEF.
//  4. LH 0x11, LW 0x12, ReqSize=11, SW 0x1000 (depth 1024) -> each RspErr=1, RspData=0; LW 0x10 afterwards unchanged.
//  5. RspReady=0, 6 back-to-back LWs tags 0..5 -> ReqReady drops after 4 accepts; head held stable;
//     RspReady=1 -> responses tags 0..5 in order, no loss or duplication.
//  6. RstN low for 1 cycle with 2 loads in flight -> RspValid 0 immediately, ReqReady 1; no stale rsp; earlier SW still read back.

Source files
------------

// File: rtl/d_mem_responder.sv
// ============================================================================
// Module      : d_mem_responder
// Description : Data-memory responder for RV32I load/store requests. It holds
//               a synchronous-read word array, formats load data and returns
//               one response per request, in request order, over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module d_mem_responder #(
  parameter int XLEN            = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int TAG_W           = 4,
  parameter int RSP_FIFO_DEPTH  = 4
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [XLEN-1:0]  ReqAddr,
  input  logic             ReqWrEn,
  input  logic [1:0]       ReqSize,
  input  logic             ReqSignExt,
  input  logic [XLEN-1:0]  ReqWrData,
  input  logic [TAG_W-1:0] ReqTag,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [XLEN-1:0]  RspData,
  output logic [TAG_W-1:0] RspTag,
  output logic             RspErr
);

  localparam int XLEN_BYTES = XLEN / 8;
  localparam int LW         = $clog2(XLEN_BYTES);
  localparam int AW         = $clog2(MEM_DEPTH_WORDS);
  localparam int PW         = $clog2(RSP_FIFO_DEPTH);
  localparam int CW         = PW + 1;

  logic [XLEN-1:0]       mem_q [MEM_DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_err;
  logic [AW-1:0]         w_idx;
  logic [XLEN_BYTES-1:0] w_be;
  logic [XLEN-1:0]       w_wdata;

  logic                  stage_valid_q;
  logic                  stage_wr_q;
  logic                  stage_err_q;
  logic [1:0]            stage_size_q;
  logic                  stage_sext_q;
  logic [LW-1:0]         stage_lo_q;
  logic [TAG_W-1:0]      stage_tag_q;
  logic [XLEN-1:0]       stage_word_q;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_fmt;

  logic [XLEN-1:0]       fifo_data_q [RSP_FIFO_DEPTH];
  logic [TAG_W-1:0]      fifo_tag_q  [RSP_FIFO_DEPTH];
  logic                  fifo_err_q  [RSP_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  w_pop;

  // Credit counts the stage slot too, so the FIFO can never overflow.
  assign ReqReady = (CW'(stage_valid_q) + count_q) < CW'(RSP_FIFO_DEPTH);
  assign w_accept = ReqValid & ReqReady;
  assign w_idx    = ReqAddr[AW+LW-1:LW];

  always_comb begin
    w_err = |ReqAddr[XLEN-1:AW+LW];
    case (ReqSize)
      2'b01:   if (ReqAddr[0]) w_err = 1'b1;
      2'b10:   if (|ReqAddr[LW-1:0]) w_err = 1'b1;
      2'b11:   w_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (ReqSize)
      2'b00: begin
        w_be    = XLEN_BYTES'(1) << ReqAddr[LW-1:0];
        w_wdata = {XLEN_BYTES{ReqWrData[7:0]}};
      end
      2'b01: begin
        w_be    = XLEN_BYTES'(3) << ReqAddr[LW-1:0];
        w_wdata = {(XLEN/16){ReqWrData[15:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = ReqWrData;
      end
    endcase
  end

  // Array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge Clk) begin
    if (w_accept && !w_err) begin
      if (ReqWrEn) begin
        for (int b = 0; b < XLEN_BYTES; b++) begin
          if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end else begin
        stage_word_q <= mem_q[w_idx];
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stage_valid_q <= 1'b0;
      stage_wr_q    <= 1'b0;
      stage_err_q   <= 1'b0;
      stage_size_q  <= 2'b00;
      stage_sext_q  <= 1'b0;
      stage_lo_q    <= '0;
      stage_tag_q   <= '0;
    end else begin
      stage_valid_q <= w_accept;
      if (w_accept) begin
        stage_wr_q   <= ReqWrEn;
        stage_err_q  <= w_err;
        stage_size_q <= ReqSize;
        stage_sext_q <= ReqSignExt;
        stage_lo_q   <= ReqAddr[LW-1:0];
        stage_tag_q  <= ReqTag;
      end
    end
  end

  assign w_byte = stage_word_q[{stage_lo_q, 3'b000} +: 8];
  assign w_half = stage_word_q[{stage_lo_q[LW-1:1], 4'b0000} +: 16];

  always_comb begin
    case (stage_size_q)
      2'b00:   w_fmt = {{(XLEN-8){stage_sext_q & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{(XLEN-16){stage_sext_q & w_half[15]}}, w_half};
      default: w_fmt = stage_word_q;
    endcase
    if (stage_err_q || stage_wr_q) w_fmt = '0;
  end

  assign w_pop = RspValid & RspReady;

  always_comb begin
    count_d = count_q;
    if (stage_valid_q && !w_pop)      count_d = count_q + CW'(1);
    else if (!stage_valid_q && w_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (stage_valid_q) begin
        fifo_data_q[wr_ptr_q] <= w_fmt;
        fifo_tag_q[wr_ptr_q]  <= stage_tag_q;
        fifo_err_q[wr_ptr_q]  <= stage_err_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign RspValid = (count_q != '0);
  assign RspData  = fifo_data_q[rd_ptr_q];
  assign RspTag   = fifo_tag_q[rd_ptr_q];
  assign RspErr   = fifo_err_q[rd_ptr_q];

endmodule

`default_nettype wire
